// File: rtl/or_nor_exerciser.sv
// Sweeps {a,b,select} over a selectable OR/NOR unit and checks its response.
// Reports a saturating error count, the first failing vector and a pass flag.
module or_nor_exerciser #(
  parameter int LATENCY = 1,
  parameter int PASSES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drv_sel,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       first_err_valid,
  output logic [2:0] first_err_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] W_LAT  = 4'(LATENCY - 1);
  localparam logic [3:0] W_LAST = 4'(PASSES - 1);

  state_t     r_state, w_state;
  logic [2:0] r_v, w_v;
  logic [3:0] r_sweep, w_sweep;
  logic [3:0] r_wait, w_wait;
  logic [3:0] r_err, w_err;
  logic       r_fvalid, w_fvalid;
  logic [2:0] r_fvec, w_fvec;
  logic       r_done, w_done;
  logic       r_busy, w_busy;
  logic       r_pass, w_pass;
  logic       w_exp;
  logic       w_mis;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state  = r_state;
    w_v      = r_v;
    w_sweep  = r_sweep;
    w_wait   = r_wait;
    w_err    = r_err;
    w_fvalid = r_fvalid;
    w_fvec   = r_fvec;
    w_done   = r_done;
    w_exp    = r_v[0] ? ~(r_v[2] | r_v[1])
                      : (r_v[2] | r_v[1]);
    w_mis    = (dut_out != w_exp);
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state  = S_SETTLE;
          w_v      = 3'd0;
          w_sweep  = 4'd0;
          w_wait   = W_LAT;
          w_err    = 4'd0;
          w_fvalid = 1'b0;
          w_fvec   = 3'd0;
          w_done   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (r_wait == 4'd0) begin
          w_state = S_CHECK;
        end else begin
          w_wait = r_wait - 4'd1;
        end
      end
      S_CHECK: begin
        if (w_mis) begin
          if (r_err != 4'd15) begin
            w_err = r_err + 4'd1;
          end
          if (!r_fvalid) begin
            w_fvalid = 1'b1;
            w_fvec   = r_v;
          end
        end
        if (r_v != 3'd7) begin
          w_v     = r_v + 3'd1;
          w_wait  = W_LAT;
          w_state = S_SETTLE;
        end else if (r_sweep != W_LAST) begin
          w_sweep = r_sweep + 4'd1;
          w_v     = 3'd0;
          w_wait  = W_LAT;
          w_state = S_SETTLE;
        end else begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state == S_SETTLE) ||
             (w_state == S_CHECK);
    w_pass = w_done && (w_err == 4'd0);
  end

  // State and result registers; reset aborts any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_v      <= 3'd0;
      r_sweep  <= 4'd0;
      r_wait   <= 4'd0;
      r_err    <= 4'd0;
      r_fvalid <= 1'b0;
      r_fvec   <= 3'd0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_v      <= w_v;
      r_sweep  <= w_sweep;
      r_wait   <= w_wait;
      r_err    <= w_err;
      r_fvalid <= w_fvalid;
      r_fvec   <= w_fvec;
      r_done   <= w_done;
      r_busy   <= w_busy;
      r_pass   <= w_pass;
    end
  end

  assign drv_a           = r_v[2];
  assign drv_b           = r_v[1];
  assign drv_sel         = r_v[0];
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_err_valid = r_fvalid;
  assign first_err_vec   = r_fvec;

endmodule
